// File: rtl/alu_serial_sequencer_pkg.sv
// alu_serial_sequencer_pkg: opcodes, FSM state encoding and opcode legality check
package alu_serial_sequencer_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
  function automatic logic is_legal_op(input logic [2:0] o);
    return o <= OP_XNOR;
  endfunction
endpackage

// File: rtl/alu_serial_shreg.sv
// alu_serial_shreg: load/shift-right register with serial input into the MSB
module alu_serial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             si_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else if (load_i) sh_q <= d_i;
    else if (shift_i) sh_q <= {si_i, sh_q[WIDTH-1:1]};
  assign q_o = sh_q;
endmodule

// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer: drives a 1-bit ALU LSB first and assembles its
// serial X/C_out back into a parallel result with final carry.
module alu_serial_sequencer
  import alu_serial_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err,
  output logic [2:0]       alu_mode,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c_in,
  input  logic             alu_x,
  input  logic             alu_c_out
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             c_q, c_d, carry_q, carry_d, err_q, err_d, ld, sh;
  logic [WIDTH-1:0] res_q, res_d, a_sh, b_sh, r_sh;
  logic             unused;
  alu_serial_shreg #(.WIDTH(WIDTH)) u_a (.clk(CLK), .rst_n(RST_N), .load_i(ld), .shift_i(sh),
    .d_i(a), .si_i(1'b0), .q_o(a_sh));
  alu_serial_shreg #(.WIDTH(WIDTH)) u_b (.clk(CLK), .rst_n(RST_N), .load_i(ld), .shift_i(sh),
    .d_i(b), .si_i(1'b0), .q_o(b_sh));
  alu_serial_shreg #(.WIDTH(WIDTH)) u_r (.clk(CLK), .rst_n(RST_N), .load_i(ld), .shift_i(sh),
    .d_i('0), .si_i(alu_x), .q_o(r_sh));
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      c_q     <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      c_q     <= c_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  // Outputs are captured on the edge entering DONE so they are valid with the done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    c_d     = c_q;
    res_d   = res_q;
    carry_d = carry_q;
    err_d   = err_q;
    ld      = 1'b0;
    sh      = 1'b0;
    case (state_q)
      ST_IDLE:
        if (start && is_legal_op(op)) begin
          ld      = 1'b1;
          op_d    = op;
          c_d     = (op == OP_ADD) ? cin : 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else if (start) begin
          res_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      ST_SHIFT: begin
        sh    = 1'b1;
        c_d   = (op_q == OP_ADD) ? alu_c_out : 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = cnt_q;
          res_d   = {alu_x, r_sh[WIDTH-1:1]};
          carry_d = (op_q == OP_ADD) ? alu_c_out : 1'b0;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign busy     = state_q != ST_IDLE;
  assign done     = state_q == ST_DONE;
  assign result   = res_q;
  assign carry    = carry_q;
  assign err      = err_q;
  assign alu_mode = (state_q == ST_SHIFT) ? op_q : 3'b000;
  assign alu_a    = a_sh[0];
  assign alu_b    = b_sh[0];
  assign alu_c_in = (op_q == OP_ADD) ? c_q : 1'b0;
  assign unused   = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1]};
endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb_alu_serial_sequencer: directed vectors against a behavioural 1-bit ALU on the alu_* ports
module tb_alu_serial_sequencer;
  logic       CLK = 1'b0, RST_N = 1'b0, start = 1'b0, cin = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, carry, err, alu_a, alu_b, alu_c_in, alu_x, alu_c_out;
  logic [7:0] result;
  logic [2:0] alu_mode;
  int         nchk = 0, nfail = 0, lat;
  logic       busy_ok, done_seen;

  always #5 CLK = ~CLK;

  alu_serial_sequencer #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .carry(carry), .err(err),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_x(alu_x), .alu_c_out(alu_c_out)
  );

  assign alu_x = (alu_mode == 3'b000) ? (alu_a ^ alu_b ^ alu_c_in) :
                 (alu_mode == 3'b001) ? (alu_a & alu_b) :
                 (alu_mode == 3'b010) ? (alu_a | alu_b) :
                 (alu_mode == 3'b011) ? (alu_a ^ alu_b) :
                 (alu_mode == 3'b100) ? ~(alu_a ^ alu_b) : 1'b0;
  assign alu_c_out = (alu_mode == 3'b000) &&
                     ((alu_a & alu_b) | (alu_a & alu_c_in) | (alu_b & alu_c_in));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                     input logic ci, input logic [7:0] er, input logic ec, input logic ee, input int el);
    start = 1'b1; op = o; a = av; b = bv; cin = ci;
    tick;
    start = 1'b0; op = 3'b111; a = 8'hA5; b = 8'h3C; cin = ~ci;
    lat = 1; busy_ok = 1'b1;
    while (!done && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      tick;
      lat++;
    end
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_busy"}, {busy_ok, busy}, 2'b11);
    chk({tag, "_result"}, result, er);
    chk({tag, "_carry"}, carry, ec);
    chk({tag, "_err"}, err, ee);
    tick;
    chk({tag, "_idle"}, {busy, done, result}, {2'b00, er});
  endtask

  initial begin
    #1;
    chk("reset_outs", {busy, done, carry, err, alu_mode, result}, 15'h0);
    tick;
    RST_N = 1'b1;
    tick;
    run("add_ff_01", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 9);
    run("add_7f_00_c1", 3'b000, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 9);
    run("add_12_34", 3'b000, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 9);
    run("and", 3'b001, 8'hC3, 8'h5A, 1'b1, 8'h42, 1'b0, 1'b0, 9);
    run("or", 3'b010, 8'hC3, 8'h5A, 1'b1, 8'hDB, 1'b0, 1'b0, 9);
    run("xor", 3'b011, 8'hC3, 8'h5A, 1'b1, 8'h99, 1'b0, 1'b0, 9);
    run("xnor", 3'b100, 8'hC3, 8'h5A, 1'b1, 8'h66, 1'b0, 1'b0, 9);
    // illegal opcode: immediate done with err, ALU never sees the opcode
    start = 1'b1; op = 3'b101; a = 8'hFF; b = 8'hFF;
    tick;
    start = 1'b0;
    chk("illegal_done", {busy, done, err, carry, result}, {4'b1110, 8'h00});
    chk("illegal_mode", alu_mode, 3'b000);
    tick;
    chk("illegal_idle", {busy, done, err}, 3'b001);
    run("after_illegal", 3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 9);
    // start during SHIFT is ignored
    start = 1'b1; op = 3'b000; a = 8'h12; b = 8'h34; cin = 1'b0;
    tick;
    start = 1'b0;
    chk("shift_mode", alu_mode, 3'b000);
    tick;
    tick;
    start = 1'b1; op = 3'b010; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick;
    start = 1'b0;
    lat = 4;
    while (!done && lat < 20) begin
      tick;
      lat++;
    end
    chk("ignore_lat", lat, 9);
    chk("ignore_result", {result, carry, err}, {8'h46, 2'b00});
    tick;
    chk("ignore_idle", {busy, done}, 2'b00);
    // reset during SHIFT aborts without a done pulse
    start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'h01; cin = 1'b0;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    chk("pre_reset_busy", {busy, alu_mode}, 4'b1000);
    RST_N = 1'b0;
    #1;
    chk("reset_abort", {busy, done, result, carry, err}, 12'h0);
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done) done_seen = 1'b1;
    end
    RST_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done) done_seen = 1'b1;
    end
    chk("reset_no_done", {done_seen, busy, result}, 10'h0);
    run("post_reset", 3'b011, 8'hC3, 8'h5A, 1'b0, 8'h99, 1'b0, 1'b0, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
